sparse_pingpong_packer: RTL and testbench

Parametrised successor of the sparse vector-packet encoder. It scans a compressed weight buffer and skips invalid entries, examining up to SCAN entries per cycle and selecting at most one. For each selected entry it gathers the matching input-activation word and packs address, weight and activation into LANES-wide ping-pong banks. Unlike the previous generation, it adds per-bank valid/ack backpressure, a lane-count output, clamped lengths and a clean drain-then-finish sequence; it sits between the weight decompressor and the PE-array feeder.

---
 rtl/sparse_pingpong_packer_pkg.sv | 19 +
 rtl/sparse_pingpong_packer_picker.sv | 29 ++
 rtl/sparse_pingpong_packer.sv | 227 ++++++++++++++++++++++
 tb/tb_sparse_pingpong_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pingpong_packer_pkg.sv
// Shared types and helpers for the sparse ping-pong packer.
//   addr_t    : three 7-bit coordinates packed into one 21-bit address
//   data_t    : signed weight/activation word at the default width
//   state_t   : controller states (IDLE, SCAN, DRAIN)
//   idx_width : width of the scan index, sized so idx never wraps
package sparse_pack_pkg;

  localparam int PKG_DW = 16;

  typedef logic [2:0][6:0] addr_t;
  typedef logic signed [PKG_DW-1:0] data_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  // Index has to reach len + SCAN - 1 without wrapping.
  function automatic int idx_width(input int w_len, input int scan);
    return $clog2(w_len + scan) + 1;
  endfunction

endpackage

// File: rtl/sparse_pingpong_packer_picker.sv
// first_valid_picker: N-wide priority encoder. Reports whether any request
// bit is set and the offset of the lowest set bit.
//   i_req    : request mask, bit 0 has highest priority
//   o_found  : at least one request is set
//   o_offset : index of the lowest set request (0 when none)
module first_valid_picker
  import sparse_pack_pkg::*;
#(
  parameter  int N  = 3,
  localparam int OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_found,
  output logic [OW-1:0] o_offset
);

  // Walk from the top so the lowest set bit is the last one assigned.
  always_comb begin
    o_found  = 1'b0;
    o_offset = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_found  = 1'b1;
        o_offset = OW'(j);
      end
    end
  end

endmodule

// File: rtl/sparse_pingpong_packer.sv
// sparse_pingpong_packer: scans a compressed weight buffer, picks at most
// one valid entry per cycle out of a SCAN-wide window, gathers its
// activation and packs (addr, w, ia) into two LANES-wide ping-pong banks
// with per-bank valid/ack handshaking.
// Ports:
//   i_clk, i_rst_n (async, active-low), i_start (honoured in IDLE only)
//   i_w_len      : entry count, clamped to W_LEN
//   i_valid_buf, i_addr_buf, i_pos_buf, i_w_data, i_ia_data : source buffers
//   i_bank_ack   : per-bank consume strobe
//   o_bank_valid, o_bank_addr, o_bank_w, o_bank_ia, o_bank_cnt : bank outputs
//   o_busy       : not IDLE;  o_finish : one-cycle done pulse
// Optional build macro SPARSE_PACK_STATS_EN adds saturating 16-bit counters
//   o_skip_cnt, o_stall_cnt, o_pkt_cnt (cleared on start and reset).
module sparse_pingpong_packer
  import sparse_pack_pkg::state_t;
  import sparse_pack_pkg::idx_width;
#(
  parameter int W_LEN = 32,
  parameter int IA_CH = 64,
  parameter int LANES = 3,
  parameter int SCAN  = 3,
  parameter int DW    = 16,
  parameter int AW    = 21
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_start,
  input  logic [$clog2(W_LEN):0]                    i_w_len,
  input  logic [W_LEN-1:0]                          i_valid_buf,
  input  logic [W_LEN-1:0][AW-1:0]                  i_addr_buf,
  input  logic [W_LEN-1:0][$clog2(IA_CH)-1:0]       i_pos_buf,
  input  logic signed [W_LEN-1:0][DW-1:0]           i_w_data,
  input  logic signed [IA_CH-1:0][DW-1:0]           i_ia_data,
  input  logic [1:0]                                i_bank_ack,
  output logic [1:0]                                o_bank_valid,
  output logic [1:0][LANES-1:0][AW-1:0]             o_bank_addr,
  output logic signed [1:0][LANES-1:0][DW-1:0]      o_bank_w,
  output logic signed [1:0][LANES-1:0][DW-1:0]      o_bank_ia,
  output logic [1:0][$clog2(LANES+1)-1:0]           o_bank_cnt,
  output logic                                      o_busy,
`ifdef SPARSE_PACK_STATS_EN
  output logic [15:0]                               o_skip_cnt,
  output logic [15:0]                               o_stall_cnt,
  output logic [15:0]                               o_pkt_cnt,
`endif
  output logic                                      o_finish
);

  localparam int LW = $clog2(W_LEN) + 1;
  localparam int IW = idx_width(W_LEN, SCAN);
  localparam int CW = $clog2(LANES + 1);
  localparam int EW = (W_LEN > 1) ? $clog2(W_LEN) : 1;
  localparam int OW = (SCAN > 1) ? $clog2(SCAN) : 1;

  state_t                                 state_q;
  logic [IW-1:0]                          len_q, idx_q;
  logic [CW-1:0]                          pos_q;
  logic                                   fill_q;
  logic                                   finish_q;
  logic [1:0]                             bank_valid_q;
  logic [1:0][LANES-1:0][AW-1:0]          bank_addr_q;
  logic signed [1:0][LANES-1:0][DW-1:0]   bank_w_q, bank_ia_q;
  logic [1:0][CW-1:0]                     bank_cnt_q;

  logic [IW-1:0]   len_d, sel_idx_d;
  logic [SCAN-1:0] win_req;
  logic            pick_found;
  logic [OW-1:0]   pick_off;
  logic [EW-1:0]   k_e;
  logic            at_end, fill_busy;

  // Clamp happens once at start; everything after compares against len_q.
  assign len_d = (i_w_len > LW'(W_LEN)) ? IW'(W_LEN) : IW'(i_w_len);

  // Entries at or beyond len are masked as invalid; since len_q <= W_LEN the
  // buffer is only read for in-range entries.
  always_comb begin
    win_req = '0;
    for (int j = 0; j < SCAN; j++) begin
      if ((idx_q + IW'(j)) < len_q) win_req[j] = i_valid_buf[EW'(idx_q + IW'(j))];
    end
  end

  first_valid_picker #(.N(SCAN)) u_picker (
    .i_req    (win_req),
    .o_found  (pick_found),
    .o_offset (pick_off)
  );

  assign sel_idx_d = idx_q + IW'(pick_off);
  assign k_e       = EW'(sel_idx_d);
  assign at_end    = (idx_q >= len_q);
  // A published fill bank blocks writes unless it is being acked this cycle.
  assign fill_busy = bank_valid_q[fill_q] & ~i_bank_ack[fill_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= sparse_pack_pkg::IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      pos_q        <= '0;
      fill_q       <= 1'b0;
      finish_q     <= 1'b0;
      bank_valid_q <= '0;
      bank_addr_q  <= '0;
      bank_w_q     <= '0;
      bank_ia_q    <= '0;
      bank_cnt_q   <= '0;
    end else begin
      finish_q     <= 1'b0;
      bank_valid_q <= bank_valid_q & ~i_bank_ack;
      case (state_q)
        sparse_pack_pkg::IDLE: begin
          if (i_start) begin
            len_q   <= len_d;
            idx_q   <= '0;
            pos_q   <= '0;
            fill_q  <= 1'b0;
            state_q <= sparse_pack_pkg::SCAN;
          end
        end
        sparse_pack_pkg::SCAN: begin
          if (at_end && (pos_q == '0)) begin
            state_q <= sparse_pack_pkg::DRAIN;
          end else if (!fill_busy) begin
            if (at_end) begin
              // Partial bank: blank the unused lanes so stale data never leaks.
              for (int l = 0; l < LANES; l++) begin
                if (l >= int'(pos_q)) begin
                  bank_addr_q[fill_q][l] <= '0;
                  bank_w_q[fill_q][l]    <= '0;
                  bank_ia_q[fill_q][l]   <= '0;
                end
              end
              bank_valid_q[fill_q] <= 1'b1;
              bank_cnt_q[fill_q]   <= pos_q;
              pos_q                <= '0;
              fill_q               <= ~fill_q;
              state_q              <= sparse_pack_pkg::DRAIN;
            end else if (pick_found) begin
              bank_addr_q[fill_q][pos_q] <= i_addr_buf[k_e];
              bank_w_q[fill_q][pos_q]    <= i_w_data[k_e];
              bank_ia_q[fill_q][pos_q]   <= i_ia_data[i_pos_buf[k_e]];
              idx_q                      <= sel_idx_d + IW'(1);
              if (pos_q == CW'(LANES - 1)) begin
                bank_valid_q[fill_q] <= 1'b1;
                bank_cnt_q[fill_q]   <= CW'(LANES);
                pos_q                <= '0;
                fill_q               <= ~fill_q;
              end else begin
                pos_q <= pos_q + CW'(1);
              end
            end else begin
              idx_q <= idx_q + IW'(SCAN);
            end
          end
        end
        sparse_pack_pkg::DRAIN: begin
          if (bank_valid_q == 2'b00) begin
            finish_q <= 1'b1;
            state_q  <= sparse_pack_pkg::IDLE;
          end
        end
        default: state_q <= sparse_pack_pkg::IDLE;
      endcase
    end
  end

  assign o_bank_valid = bank_valid_q;
  assign o_bank_addr  = bank_addr_q;
  assign o_bank_w     = bank_w_q;
  assign o_bank_ia    = bank_ia_q;
  assign o_bank_cnt   = bank_cnt_q;
  assign o_busy       = (state_q != sparse_pack_pkg::IDLE);
  assign o_finish     = finish_q;

`ifdef SPARSE_PACK_STATS_EN
  localparam int KW = $clog2(SCAN + 1);

  logic [15:0]   skip_cnt_q, stall_cnt_q, pkt_cnt_q;
  logic [KW-1:0] in_range_n, skip_n;
  logic          in_scan, step_ev, stall_ev, pub_ev;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    in_range_n = '0;
    for (int j = 0; j < SCAN; j++) begin
      if ((idx_q + IW'(j)) < len_q) in_range_n = in_range_n + KW'(1);
    end
  end

  // Entries ahead of the pick, or the whole in-range window when empty.
  assign skip_n   = pick_found ? KW'(pick_off) : in_range_n;
  assign in_scan  = (state_q == sparse_pack_pkg::SCAN);
  assign step_ev  = in_scan && !fill_busy && !at_end;
  assign stall_ev = in_scan && fill_busy && !(at_end && (pos_q == '0));
  assign pub_ev   = in_scan && !fill_busy &&
                    ((at_end && (pos_q != '0)) ||
                     (!at_end && pick_found && (pos_q == CW'(LANES - 1))));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skip_cnt_q  <= '0;
      stall_cnt_q <= '0;
      pkt_cnt_q   <= '0;
    end else if ((state_q == sparse_pack_pkg::IDLE) && i_start) begin
      skip_cnt_q  <= '0;
      stall_cnt_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (step_ev)  skip_cnt_q  <= sat_add16(skip_cnt_q, 16'(skip_n));
      if (stall_ev) stall_cnt_q <= sat_add16(stall_cnt_q, 16'd1);
      if (pub_ev)   pkt_cnt_q   <= sat_add16(pkt_cnt_q, 16'd1);
    end
  end

  assign o_skip_cnt  = skip_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_pkt_cnt   = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_sparse_pingpong_packer.sv
module tb_sparse_pingpong_packer;

  localparam int W_LEN = 32, IA_CH = 64, LANES = 3, SCAN = 3, DW = 16, AW = 21;
  localparam int LW = $clog2(W_LEN) + 1;
  localparam int PW = $clog2(IA_CH);
  localparam int CW = $clog2(LANES + 1);

  logic clk = 1'b0;
  logic rst_n, start;
  logic [LW-1:0] w_len;
  logic [W_LEN-1:0] valid_buf;
  logic [W_LEN-1:0][AW-1:0] addr_buf;
  logic [W_LEN-1:0][PW-1:0] pos_buf;
  logic signed [W_LEN-1:0][DW-1:0] w_data;
  logic signed [IA_CH-1:0][DW-1:0] ia_data;
  logic [1:0] ack, bank_valid;
  logic [1:0][LANES-1:0][AW-1:0] bank_addr;
  logic signed [1:0][LANES-1:0][DW-1:0] bank_w, bank_ia;
  logic [1:0][CW-1:0] bank_cnt;
  logic busy, finish;
`ifdef SPARSE_PACK_STATS_EN
  logic [15:0] skip_cnt, stall_cnt, pkt_cnt;
`endif

  sparse_pingpong_packer #(
    .W_LEN(W_LEN), .IA_CH(IA_CH), .LANES(LANES), .SCAN(SCAN), .DW(DW), .AW(AW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_w_len(w_len),
    .i_valid_buf(valid_buf), .i_addr_buf(addr_buf), .i_pos_buf(pos_buf),
    .i_w_data(w_data), .i_ia_data(ia_data), .i_bank_ack(ack),
    .o_bank_valid(bank_valid), .o_bank_addr(bank_addr), .o_bank_w(bank_w),
    .o_bank_ia(bank_ia), .o_bank_cnt(bank_cnt), .o_busy(busy),
`ifdef SPARSE_PACK_STATS_EN
    .o_skip_cnt(skip_cnt), .o_stall_cnt(stall_cnt), .o_pkt_cnt(pkt_cnt),
`endif
    .o_finish(finish)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Packet log filled while draining a run.
  int n_pk, n_fin, first_v, fin_cyc, extra_fin;
  int pk_bank [16];
  int pk_cnt  [16];
  logic [AW-1:0] pk_addr [16][LANES];
  logic [DW-1:0] pk_w    [16][LANES];
  logic [DW-1:0] pk_ia   [16][LANES];

  task automatic load_buffers(input int len, input logic [W_LEN-1:0] vmask);
    w_len     = LW'(len);
    valid_buf = vmask;
    for (int i = 0; i < W_LEN; i++) begin
      addr_buf[i] = AW'(i * 1000 + 7);
      pos_buf[i]  = PW'((i * 5 + 7) % 64);
      w_data[i]   = DW'(i * 37 - 300);
    end
    for (int j = 0; j < IA_CH; j++) ia_data[j] = DW'(j * 3 - 50);
  endtask

  task automatic start_run(input int len, input logic [W_LEN-1:0] vmask);
    load_buffers(len, vmask);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Acks every published bank one cycle after it appears, logs it, and
  // returns on o_finish or when the cycle budget runs out.
  task automatic run_until_finish(input int max_cyc);
    n_pk = 0; n_fin = 0; first_v = -1; fin_cyc = -1; extra_fin = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      ack = '0;
      if (first_v < 0 && bank_valid[0]) first_v = c;
      for (int b = 0; b < 2; b++) begin
        if (bank_valid[b]) begin
          if (n_pk < 16) begin
            pk_bank[n_pk] = b;
            pk_cnt[n_pk]  = int'(bank_cnt[b]);
            for (int l = 0; l < LANES; l++) begin
              pk_addr[n_pk][l] = bank_addr[b][l];
              pk_w[n_pk][l]    = bank_w[b][l];
              pk_ia[n_pk][l]   = bank_ia[b][l];
            end
          end
          n_pk++;
          ack[b] = 1'b1;
        end
      end
      if (finish) begin
        n_fin++;
        fin_cyc = c;
        break;
      end
    end
    ack = '0;
    repeat (4) begin
      @(negedge clk);
      if (finish) extra_fin++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ack = '0;
    load_buffers(0, '0);
    repeat (3) @(negedge clk);
    checks++; if (bank_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", bank_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
    checks++; if (bank_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", bank_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dense();
    start_run(6, '1);
    run_until_finish(40);
    checks++; if (n_fin !== 1 || extra_fin !== 0) begin errors++; $display("FAIL dense_finish got %0d+%0d want 1+0", n_fin, extra_fin); end
    checks++; if (n_pk !== 2) begin errors++; $display("FAIL dense_npk got %0d want 2", n_pk); end
    checks++; if (first_v !== LANES) begin errors++; $display("FAIL dense_latency got %0d want %0d", first_v, LANES); end
    for (int p = 0; p < 2; p++) begin
      checks++; if (pk_bank[p] !== p || pk_cnt[p] !== 3) begin errors++; $display("FAIL dense_bank%0d got bank %0d cnt %0d want bank %0d cnt 3", p, pk_bank[p], pk_cnt[p], p); end
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (pk_addr[p][l] !== addr_buf[3*p+l] || pk_w[p][l] !== w_data[3*p+l] || pk_ia[p][l] !== ia_data[pos_buf[3*p+l]]) begin
          errors++; $display("FAIL dense_lane p%0d l%0d got %h/%h/%h want entry %0d", p, l, pk_addr[p][l], pk_w[p][l], pk_ia[p][l], 3*p+l);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dense_idle got busy %b want 0", busy); end
  endtask

  task automatic test_sparse_skip();
    // Entries 3 and 6 valid: pos 22/37, w -189/-78, ia 16/61, addr 3007/6007.
    start_run(7, 32'h0000_0048);
    run_until_finish(40);
    checks++; if (n_pk !== 1 || n_fin !== 1) begin errors++; $display("FAIL sparse_npk got %0d pk %0d fin want 1 1", n_pk, n_fin); end
    checks++; if (pk_bank[0] !== 0 || pk_cnt[0] !== 2) begin errors++; $display("FAIL sparse_cnt got bank %0d cnt %0d want 0 2", pk_bank[0], pk_cnt[0]); end
    checks++; if (pk_addr[0][0] !== 21'd3007 || pk_w[0][0] !== 16'hFF43 || pk_ia[0][0] !== 16'h0010) begin errors++; $display("FAIL sparse_lane0 got %0d/%h/%h want 3007/ff43/0010", pk_addr[0][0], pk_w[0][0], pk_ia[0][0]); end
    checks++; if (pk_addr[0][1] !== 21'd6007 || pk_w[0][1] !== 16'hFFB2 || pk_ia[0][1] !== 16'h003D) begin errors++; $display("FAIL sparse_lane1 got %0d/%h/%h want 6007/ffb2/003d", pk_addr[0][1], pk_w[0][1], pk_ia[0][1]); end
    checks++; if (pk_addr[0][2] !== '0 || pk_w[0][2] !== '0 || pk_ia[0][2] !== '0) begin errors++; $display("FAIL sparse_lane2 got %h/%h/%h want zeros", pk_addr[0][2], pk_w[0][2], pk_ia[0][2]); end
`ifdef SPARSE_PACK_STATS_EN
    checks++; if (skip_cnt !== 16'd5 || pkt_cnt !== 16'd1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL sparse_stats got skip %0d pkt %0d stall %0d want 5 1 0", skip_cnt, pkt_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    start_run(9, '1);
    repeat (8) @(negedge clk);
    checks++; if (bank_valid !== 2'b11 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall got valid %b busy %b want 11 1", bank_valid, busy); end
    checks++; if (dut.idx_q !== 7'd6) begin errors++; $display("FAIL bp_idx got %0d want 6", dut.idx_q); end
    checks++; if (bank_addr[0][2] !== addr_buf[2] || bank_addr[1][2] !== addr_buf[5] || bank_cnt !== {2'd3, 2'd3}) begin errors++; $display("FAIL bp_banks got %0d %0d cnt %h", bank_addr[0][2], bank_addr[1][2], bank_cnt); end
    // A start pulse while busy must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (dut.idx_q !== 7'd6 || bank_valid !== 2'b11) begin errors++; $display("FAIL bp_start_ignored got idx %0d valid %b want 6 11", dut.idx_q, bank_valid); end
    ack = 2'b01;
    @(negedge clk);
    ack = 2'b00;
    checks++; if (bank_valid !== 2'b10 || bank_addr[0][0] !== addr_buf[6]) begin errors++; $display("FAIL bp_resume got valid %b lane0 %0d want 10 %0d", bank_valid, bank_addr[0][0], addr_buf[6]); end
    repeat (2) @(negedge clk);
    checks++; if (bank_valid !== 2'b11 || bank_cnt[0] !== 2'd3) begin errors++; $display("FAIL bp_repub got valid %b cnt %0d want 11 3", bank_valid, bank_cnt[0]); end
    for (int l = 0; l < LANES; l++) begin
      checks++; if (bank_addr[0][l] !== addr_buf[6+l] || bank_w[0][l] !== w_data[6+l]) begin errors++; $display("FAIL bp_lane%0d got %0d/%h want entry %0d", l, bank_addr[0][l], bank_w[0][l], 6+l); end
    end
    run_until_finish(20);
    checks++; if (n_fin !== 1 || n_pk !== 2) begin errors++; $display("FAIL bp_drain got fin %0d pk %0d want 1 2", n_fin, n_pk); end
  endtask

  task automatic test_empty_clamp();
    start_run(0, '1);
    run_until_finish(6);
    checks++; if (n_fin !== 1 || n_pk !== 0 || fin_cyc > 3) begin errors++; $display("FAIL empty got fin %0d pk %0d cyc %0d want 1 0 <=3", n_fin, n_pk, fin_cyc); end
    start_run(40, '1);
    run_until_finish(150);
    checks++; if (n_fin !== 1 || n_pk !== 11) begin errors++; $display("FAIL clamp_npk got fin %0d pk %0d want 1 11", n_fin, n_pk); end
    for (int p = 0; p < 10; p++) begin
      checks++; if (pk_addr[p][0] !== addr_buf[3*p] || pk_bank[p] !== (p % 2) || pk_cnt[p] !== 3) begin errors++; $display("FAIL clamp_pkt%0d got %0d b%0d c%0d", p, pk_addr[p][0], pk_bank[p], pk_cnt[p]); end
    end
    checks++; if (pk_cnt[10] !== 2 || pk_addr[10][0] !== addr_buf[30] || pk_addr[10][1] !== addr_buf[31] || pk_w[10][2] !== '0) begin errors++; $display("FAIL clamp_tail got cnt %0d %0d %0d w2 %h", pk_cnt[10], pk_addr[10][0], pk_addr[10][1], pk_w[10][2]); end
  endtask

  task automatic test_reset_mid_run();
    start_run(6, '1);
    repeat (4) @(negedge clk);
    checks++; if (bank_valid !== 2'b01 || dut.pos_q !== 2'd1) begin errors++; $display("FAIL rst_pre got valid %b pos %0d want 01 1", bank_valid, dut.pos_q); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bank_valid !== 2'b00 || busy !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL rst_ctrl got valid %b busy %b fin %b want 0", bank_valid, busy, finish); end
    checks++; if (bank_addr !== '0 || bank_w !== '0 || bank_ia !== '0 || bank_cnt !== '0) begin errors++; $display("FAIL rst_data got nonzero bank data"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(3, '1);
    run_until_finish(30);
    checks++; if (n_fin !== 1 || n_pk !== 1 || pk_bank[0] !== 0 || pk_cnt[0] !== 3) begin errors++; $display("FAIL rst_rerun got fin %0d pk %0d bank %0d cnt %0d", n_fin, n_pk, pk_bank[0], pk_cnt[0]); end
    checks++; if (pk_addr[0][0] !== addr_buf[0] || pk_ia[0][2] !== ia_data[pos_buf[2]]) begin errors++; $display("FAIL rst_rerun_data got %0d %h", pk_addr[0][0], pk_ia[0][2]); end
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse_skip();
    test_backpressure();
    test_empty_clamp();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
